// File: rtl/decode_stage.sv
// Registered decode stage: one instruction per cycle in, one decoded bundle out,
// with load-use bubble insertion, flush and illegal-opcode flagging.
module decode_stage #(
    parameter int DATA_WIDTH = 32,
    parameter bit LOGIC_ZEXT = 1'b1,
    parameter bit HAZARD_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           ibus,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2:0]            S,
    output logic                  Cin,
    output logic                  imm,
    output logic                  load,
    output logic                  store,
    output logic                  set,
    output logic                  eq,
    output logic                  eq_type,
    output logic [1:0]            set_type,
    output logic                  illegal,
    output logic [4:0]            rs,
    output logic [4:0]            rt,
    output logic [4:0]            rd,
    output logic [DATA_WIDTH-1:0] imm_ext,
    output logic                  hazard
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000011;
    localparam logic [5:0] OP_SUBI = 6'b000010;
    localparam logic [5:0] OP_XORI = 6'b000001;
    localparam logic [5:0] OP_ANDI = 6'b001111;
    localparam logic [5:0] OP_ORI  = 6'b001100;
    localparam logic [5:0] OP_LW   = 6'b011110;
    localparam logic [5:0] OP_SW   = 6'b011111;
    localparam logic [5:0] OP_BEQ  = 6'b110000;
    localparam logic [5:0] OP_BNE  = 6'b110001;

    logic [5:0]            w_op;
    logic [5:0]            w_funct;
    logic [15:0]           w_imm16;
    logic [2:0]            w_S;
    logic                  w_Cin, w_imm, w_load, w_store, w_set, w_eq, w_eq_type, w_illegal;
    logic [1:0]            w_set_type;
    logic                  w_logic_op;
    logic [DATA_WIDTH-1:0] w_ext;
    logic                  w_uses_rt;
    logic                  w_src_match;
    logic                  w_take;

    logic                  r_valid;
    logic [2:0]            r_S;
    logic                  r_Cin, r_imm, r_load, r_store, r_set, r_eq, r_eq_type, r_illegal;
    logic [1:0]            r_set_type;
    logic [4:0]            r_rs, r_rt, r_rd;
    logic [DATA_WIDTH-1:0] r_imm_ext;

    assign w_op    = ibus[31:26];
    assign w_funct = ibus[5:0];
    assign w_imm16 = ibus[15:0];

    always_comb begin
        w_S        = 3'b000;
        w_Cin      = 1'b0;
        w_imm      = 1'b0;
        w_load     = 1'b0;
        w_store    = 1'b0;
        w_set      = 1'b0;
        w_eq       = 1'b0;
        w_eq_type  = 1'b0;
        w_set_type = 2'b00;
        w_illegal  = 1'b0;
        case (w_op)
            OP_R: begin
                case (w_funct)
                    6'b000011: w_S = 3'b010;
                    6'b000010: begin w_S = 3'b011; w_Cin = 1'b1; end
                    6'b000001: w_S = 3'b000;
                    6'b000111: w_S = 3'b110;
                    6'b000100: w_S = 3'b100;
                    6'b110110: begin w_S = 3'b011; w_Cin = 1'b1; w_set = 1'b1; end
                    6'b110111: begin
                        w_S = 3'b011; w_Cin = 1'b1; w_set = 1'b1; w_set_type = 2'b10;
                    end
                    default:   w_illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin w_S = 3'b010; w_imm = 1'b1; end
            OP_SUBI: begin w_S = 3'b011; w_Cin = 1'b1; w_imm = 1'b1; end
            OP_XORI: begin w_S = 3'b000; w_imm = 1'b1; end
            OP_ANDI: begin w_S = 3'b110; w_imm = 1'b1; end
            OP_ORI:  begin w_S = 3'b100; w_imm = 1'b1; end
            OP_LW:   begin w_S = 3'b010; w_imm = 1'b1; w_load = 1'b1; end
            OP_SW:   begin w_S = 3'b010; w_imm = 1'b1; w_store = 1'b1; end
            OP_BEQ:  begin w_eq = 1'b1; w_store = 1'b1; end
            OP_BNE:  begin w_eq = 1'b1; w_eq_type = 1'b1; w_store = 1'b1; end
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_logic_op = (w_op == OP_XORI) | (w_op == OP_ANDI) | (w_op == OP_ORI);
    assign w_ext = (LOGIC_ZEXT && w_logic_op) ? DATA_WIDTH'(w_imm16)
                                              : DATA_WIDTH'($signed(w_imm16));

    // Only these formats read ibus.rt as a source; elsewhere rt is a destination.
    assign w_uses_rt   = (w_op == OP_R) | (w_op == OP_SW) | (w_op == OP_BEQ) | (w_op == OP_BNE);
    assign w_src_match = (ibus[25:21] == r_rt) | (w_uses_rt & (ibus[20:16] == r_rt));
    assign hazard      = HAZARD_EN & r_valid & r_load & (r_rt != 5'd0) & in_valid & w_src_match;

    assign in_ready = (~r_valid | out_ready) & ~hazard & ~flush;
    assign w_take   = in_valid & in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_S        <= 3'b000;
            r_Cin      <= 1'b0;
            r_imm      <= 1'b0;
            r_load     <= 1'b0;
            r_store    <= 1'b0;
            r_set      <= 1'b0;
            r_eq       <= 1'b0;
            r_eq_type  <= 1'b0;
            r_set_type <= 2'b00;
            r_illegal  <= 1'b0;
            r_rs       <= 5'd0;
            r_rt       <= 5'd0;
            r_rd       <= 5'd0;
            r_imm_ext  <= '0;
        end else begin
            // A hazard leaves w_take low, so an out_ready cycle loads a bubble.
            if (flush)
                r_valid <= 1'b0;
            else if (~r_valid | out_ready)
                r_valid <= w_take;
            if (w_take) begin
                r_S        <= w_S;
                r_Cin      <= w_Cin;
                r_imm      <= w_imm;
                r_load     <= w_load;
                r_store    <= w_store;
                r_set      <= w_set;
                r_eq       <= w_eq;
                r_eq_type  <= w_eq_type;
                r_set_type <= w_set_type;
                r_illegal  <= w_illegal;
                r_rs       <= ibus[25:21];
                r_rt       <= ibus[20:16];
                r_rd       <= ibus[15:11];
                r_imm_ext  <= w_ext;
            end
        end
    end

    assign out_valid = r_valid;
    assign S         = r_S;
    assign Cin       = r_Cin;
    assign imm       = r_imm;
    assign load      = r_load;
    assign store     = r_store;
    assign set       = r_set;
    assign eq        = r_eq;
    assign eq_type   = r_eq_type;
    assign set_type  = r_set_type;
    assign illegal   = r_illegal;
    assign rs        = r_rs;
    assign rt        = r_rt;
    assign rd        = r_rd;
    assign imm_ext   = r_imm_ext;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: default instance plus one with sign-extended
// logic immediates and hazard detection disabled, both on the same stimulus.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] ibus;

    logic        in_ready, out_valid, Cin, imm, load, store, set, eq, eq_type, illegal, hazard;
    logic [2:0]  S;
    logic [1:0]  set_type;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_ext;

    logic        b_in_ready, b_out_valid, b_Cin, b_imm, b_load, b_store, b_set, b_eq, b_eq_type;
    logic        b_illegal, b_hazard;
    logic [2:0]  b_S;
    logic [1:0]  b_set_type;
    logic [4:0]  b_rs, b_rt, b_rd;
    logic [31:0] b_imm_ext;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decode_stage #(.DATA_WIDTH(32), .LOGIC_ZEXT(1'b1), .HAZARD_EN(1'b1)) u_a (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .ibus(ibus), .out_valid(out_valid), .out_ready(out_ready), .S(S), .Cin(Cin), .imm(imm),
        .load(load), .store(store), .set(set), .eq(eq), .eq_type(eq_type), .set_type(set_type),
        .illegal(illegal), .rs(rs), .rt(rt), .rd(rd), .imm_ext(imm_ext), .hazard(hazard)
    );

    decode_stage #(.DATA_WIDTH(32), .LOGIC_ZEXT(1'b0), .HAZARD_EN(1'b0)) u_b (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .ibus(ibus), .out_valid(b_out_valid), .out_ready(out_ready), .S(b_S), .Cin(b_Cin),
        .imm(b_imm), .load(b_load), .store(b_store), .set(b_set), .eq(b_eq), .eq_type(b_eq_type),
        .set_type(b_set_type), .illegal(b_illegal), .rs(b_rs), .rt(b_rt), .rd(b_rd),
        .imm_ext(b_imm_ext), .hazard(b_hazard)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] s, t, d, input logic [5:0] f);
        return {6'b000000, s, t, d, 5'b00000, f};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s, t,
                                          input logic [15:0] i);
        return {op, s, t, i};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr);
        ibus     = instr;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ibus = '0;
        #12;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_S", 32'(S), 0);
        chk("rst_set_type", 32'(set_type), 0);
        reset = 1'b0;

        // Reset mid-stream clears outputs without a clock edge
        send(rtype(5'd1, 5'd2, 5'd3, 6'b000010));
        chk("sub_valid", 32'(out_valid), 1);
        chk("sub_S", 32'(S), 32'b011);
        reset = 1'b1; #1;
        chk("async_rst_valid", 32'(out_valid), 0);
        chk("async_rst_S", 32'(S), 0);
        reset = 1'b0; #1;
        chk("post_rst_in_ready", 32'(in_ready), 1);

        send(rtype(5'd1, 5'd2, 5'd3, 6'b000011));
        chk("add_valid", 32'(out_valid), 1);
        chk("add_S", 32'(S), 32'b010);
        chk("add_Cin", 32'(Cin), 0);
        chk("add_imm", 32'(imm), 0);
        chk("add_rd", 32'(rd), 3);

        // Immediate extension
        send(itype(6'b000011, 5'd1, 5'd2, 16'hFFF0));
        chk("addi_ext", imm_ext, 32'hFFFFFFF0);
        chk("addi_imm", 32'(imm), 1);
        send(itype(6'b001111, 5'd1, 5'd2, 16'hFFF0));
        chk("andi_zext", imm_ext, 32'h0000FFF0);
        chk("andi_sext", b_imm_ext, 32'hFFFFFFF0);
        chk("andi_S", 32'(S), 32'b110);

        // SLE held under back-pressure, next instruction waiting on ibus
        send(rtype(5'd4, 5'd5, 5'd6, 6'b110111));
        out_ready = 1'b0;
        ibus      = rtype(5'd1, 5'd2, 5'd3, 6'b000001);
        in_valid  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("hold_in_ready", 32'(in_ready), 0);
            chk("hold_S", 32'(S), 32'b011);
            chk("hold_set", 32'(set), 1);
            chk("hold_set_type", 32'(set_type), 32'b10);
            tick();
        end
        out_ready = 1'b1; #1;
        chk("release_in_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("xor_S", 32'(S), 0);
        chk("xor_set", 32'(set), 0);

        // Load-use hazard: LW rt=5 then SUB rs=5
        send(itype(6'b011110, 5'd0, 5'd5, 16'h0004));
        chk("lw_load", 32'(load), 1);
        ibus = rtype(5'd5, 5'd7, 5'd8, 6'b000010); in_valid = 1'b1; #1;
        chk("hz_a", 32'(hazard), 1);
        chk("hz_in_ready", 32'(in_ready), 0);
        chk("hz_b_off", 32'(b_hazard), 0);
        tick();
        chk("bubble_valid", 32'(out_valid), 0);
        chk("b_nobubble_valid", 32'(b_out_valid), 1);
        chk("b_sub_S", 32'(b_S), 32'b011);
        chk("hz_cleared", 32'(hazard), 0);
        tick();
        in_valid = 1'b0;
        chk("hz_sub_valid", 32'(out_valid), 1);
        chk("hz_sub_S", 32'(S), 32'b011);
        chk("hz_sub_Cin", 32'(Cin), 1);

        // LW rt=0 never stalls
        send(itype(6'b011110, 5'd0, 5'd0, 16'h0004));
        ibus = rtype(5'd0, 5'd9, 5'd10, 6'b000011); in_valid = 1'b1; #1;
        chk("lw_r0_hazard", 32'(hazard), 0);
        tick();
        in_valid = 1'b0;
        chk("lw_r0_valid", 32'(out_valid), 1);
        chk("lw_r0_S", 32'(S), 32'b010);

        // rt is a source only for R/SW/BEQ/BNE
        send(itype(6'b011110, 5'd0, 5'd5, 16'h0000));
        ibus = itype(6'b000011, 5'd1, 5'd5, 16'h0001); in_valid = 1'b1; #1;
        chk("addi_rt_nohz", 32'(hazard), 0);
        ibus = itype(6'b011111, 5'd1, 5'd5, 16'h0001); #1;
        chk("sw_rt_hz", 32'(hazard), 1);
        in_valid = 1'b0;
        tick();

        // Illegal opcode and illegal funct
        send(itype(6'b111111, 5'd1, 5'd2, 16'h1234));
        chk("ill_op", 32'(illegal), 1);
        chk("ill_valid", 32'(out_valid), 1);
        chk("ill_flags", {25'd0, S, imm, load, store, set, eq}, 0);
        send(rtype(5'd1, 5'd2, 5'd3, 6'b101010));
        chk("ill_funct", 32'(illegal), 1);

        send(itype(6'b110001, 5'd1, 5'd2, 16'hFFFF));
        chk("bne_flags", {28'd0, eq, eq_type, store, illegal}, 32'b1110);
        chk("bne_ext", imm_ext, 32'hFFFFFFFF);

        // Flush dominates in_valid and out_ready
        ibus = itype(6'b000011, 5'd1, 5'd2, 16'h1234); in_valid = 1'b1; flush = 1'b1; #1;
        chk("flush_in_ready", 32'(in_ready), 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 0);
        tick();
        chk("flush_never_out", 32'(out_valid), 0);
        tick();
        chk("empty_valid", 32'(out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered, handshaked successor to the combinational opcode decoder. It accepts one 32-bit instruction per cycle, decodes the team's ALU/memory/branch encoding, and extracts the register fields and the extended immediate. All outputs come from a single pipeline register feeding execute. It detects load-use hazards against the instruction it holds, inserts a bubble when needed, and supports flush and illegal-opcode flagging.

Parameters:
DATA_WIDTH, 32, width of imm_ext; must be >= 16.
LOGIC_ZEXT, 1, 1 = XORI/ANDI/ORI zero-extend the immediate; 0 = all immediates sign-extend.
HAZARD_EN, 1, 1 = load-use bubble insertion enabled; 0 = hazard is never asserted.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous active-high reset.
flush  in  1  discard the held instruction and the input for this cycle.
in_valid  in  1  ibus holds an instruction.
in_ready  out  1  stage accepts ibus this cycle.
ibus  in  32  instruction: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0].
out_valid  out  1  decoded bundle valid.
out_ready  in  1  execute consumes the bundle.
S  out  3  ALU select.
Cin  out  1  ALU carry-in.
imm  out  1  B operand is imm_ext.
load, store, set, eq, eq_type  out  1 each  control flags.
set_type  out  2  00 = SLT, 10 = SLE.
illegal  out  1  undefined opcode/funct.
rs, rt, rd  out  5 each  register fields.
imm_ext  out  DATA_WIDTH  extended immediate.
hazard  out  1  combinational load-use stall indicator.

Behaviour:
- Reset, asynchronous: out_valid=0. Every other registered output=0, including S=000 and set_type=00.
- Decode table. R-type is opcode 000000, selected by funct:
  - ADD 000011: S=010, Cin=0.
  - SUB 000010: S=011, Cin=1.
  - XOR 000001: S=000.
  - AND 000111: S=110.
  - OR 000100: S=100.
  - SLT 110110: S=011, Cin=1, set=1, set_type=00.
  - SLE 110111: S=011, Cin=1, set=1, set_type=10.
  - R-type always has imm=0.
- Immediate opcodes, all with imm=1:
  - ADDI 000011: S=010.
  - SUBI 000010: S=011, Cin=1.
  - XORI 000001: S=000.
  - ANDI 001111: S=110.
  - ORI 001100: S=100.
  - LW 011110: S=010, load=1.
  - SW 011111: S=010, store=1.
- Branches:
  - BEQ 110000: eq=1, eq_type=0, store=1.
  - BNE 110001: eq=1, eq_type=1, store=1.
- Unlisted opcode or R-type funct: illegal=1, all other flags 0, S=000. The instruction still propagates.
- Defaults: every field not named is 0. There are no X outputs.
- Extension: the imm[15:0] extension rule selects by opcode. Logic immediates use zero-extension when LOGIC_ZEXT=1. Everything else, and everything when LOGIC_ZEXT=0, sign-extends to DATA_WIDTH.
- Handshake: the transfer "in" occurs when in_valid & in_ready; the transfer "out" occurs when out_valid & out_ready.
  - in_ready = (!out_valid | out_ready) & !hazard & !flush.
  - Latency is 1 cycle: a bundle accepted at edge N is visible after edge N.
- Holding: while out_valid & !out_ready, all outputs hold stable.
- Hazard: hazard = HAZARD_EN & out_valid & load & (rt != 0) & in_valid & src_match.
  - src_match = (ibus.rs == rt), or (ibus.rt == rt when the incoming instruction is R-type, SW, BEQ or BNE).
  - When hazard & out_ready: the load retires, the register loads a bubble (out_valid=0 next cycle), and the instruction is accepted the following cycle.
  - Hazard never lasts more than one out_ready cycle.
- Flush: on the next edge out_valid=0 and the input is not accepted. Flush dominates in_valid, hazard and out_ready.
- Empty: when !out_valid and !in_valid, out_valid stays 0 and the payload registers may hold stale data.
- Reset mid-transfer drops the bundle. The first in_valid after reset deassertion is accepted (in_ready=1).

Test Plan:
1. Reset asserted mid-stream: out_valid=0 and S=000 immediately, with no clock edge. After release, ADD (funct 000011) with out_ready=1 gives S=010, Cin=0, imm=0 one cycle later.
2. ADDI with imm=16'hFFF0 gives imm_ext=32'hFFFFFFF0. ANDI with 16'hFFF0 gives 32'h0000FFF0 when LOGIC_ZEXT=1 and 32'hFFFFFFF0 when LOGIC_ZEXT=0.
3. Hold out_ready=0 for 3 cycles after SLE is accepted: in_ready=0 and S=011, set=1, set_type=10 stay stable; releasing out_ready accepts the next instruction in the same cycle.
4. LW rt=5 followed by SUB rs=5: hazard=1 for one cycle, a bubble appears (out_valid=0), then SUB emits S=011, Cin=1. With LW rt=0 there is no bubble, and with HAZARD_EN=0 there is no bubble either.
5. Opcode 111111 gives illegal=1 with all flags 0. BNE gives eq=1, eq_type=1, store=1.
6. flush asserted together with in_valid and out_ready: the next cycle has out_valid=0, and the flushed instruction never appears on the outputs.
